// File: rtl/cim_input_sequencer.sv
// Bit-serial CIM input sequencer: steps one latched IFM vector through every
// (input bit plane, weight column) pair, wb inner loop, ib outer loop.
module cim_input_sequencer #(
  parameter int BIT_W   = 8,
  parameter int OUY     = 8,
  parameter int BIT_IFM = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OUY*BIT_IFM-1:0]       in_ifm,
  input  logic                         stall,
  output logic [OUY-1:0]               DAC_BITS,
  output logic [$clog2(BIT_W)-1:0]     COL_SEL,
  output logic [BIT_W-1:0]             WEIGHT_BIT_POSITION,
  output logic [$clog2(OUY):0]         ONES_COUNTER,
  output logic [$clog2(BIT_IFM)-1:0]   INPUT_BIT_POSITION,
  output logic                         seq_valid,
  output logic                         seq_last,
  output logic                         busy
);

  localparam int CW = $clog2(BIT_W);
  localparam int IW = $clog2(BIT_IFM);
  localparam int OW = $clog2(OUY) + 1;
  localparam logic [CW-1:0] WB_MAX = CW'(BIT_W - 1);
  localparam logic [IW-1:0] IB_MAX = IW'(BIT_IFM - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_r, state_n;
  logic [OUY*BIT_IFM-1:0]  ifm_r, ifm_n;
  logic [IW-1:0]           ib_n;
  logic [CW-1:0]           wb_n;
  logic                    valid_n, new_plane_s, load_s;
  logic [OUY-1:0]          dac_n;
  logic [OW-1:0]           ones_n;
  logic [BIT_W-1:0]        wbp_n;
  logic                    last_n;

  function automatic logic [OUY-1:0] plane_bits(input logic [OUY*BIT_IFM-1:0] v,
                                                input logic [IW-1:0] b);
    logic [OUY-1:0] p;
    p = {OUY{1'b0}};
    for (int r = 0; r < OUY; r++) p[r] = v[r*BIT_IFM + int'(b)];
    return p;
  endfunction

  function automatic logic [OW-1:0] popcount(input logic [OUY-1:0] v);
    logic [OW-1:0] c;
    c = {OW{1'b0}};
    for (int r = 0; r < OUY; r++) c = c + {{(OW-1){1'b0}}, v[r]};
    return c;
  endfunction

  assign in_ready = (state_r == IDLE) || (seq_last && !stall);
  assign busy     = (state_r == RUN);
  assign load_s   = in_valid && in_ready;

  // Next step: accept a vector, advance wb/ib, finish, or hold under stall.
  always_comb begin
    state_n     = state_r;
    ifm_n       = ifm_r;
    ib_n        = INPUT_BIT_POSITION;
    wb_n        = COL_SEL;
    valid_n     = seq_valid;
    new_plane_s = 1'b0;
    if (load_s) begin
      state_n     = RUN;
      ifm_n       = in_ifm;
      ib_n        = {IW{1'b0}};
      wb_n        = {CW{1'b0}};
      valid_n     = 1'b1;
      new_plane_s = 1'b1;
    end else if (state_r == RUN && !stall && !seq_last) begin
      if (COL_SEL == WB_MAX) begin
        wb_n        = {CW{1'b0}};
        ib_n        = INPUT_BIT_POSITION + {{(IW-1){1'b0}}, 1'b1};
        new_plane_s = 1'b1;
      end else begin
        wb_n = COL_SEL + {{(CW-1){1'b0}}, 1'b1};
      end
    end else if (state_r == RUN && !stall) begin
      state_n = IDLE;
      ib_n    = {IW{1'b0}};
      wb_n    = {CW{1'b0}};
      valid_n = 1'b0;
    end else begin
      state_n = state_r;
    end

    // Popcount only refreshes on a plane change; within a plane DAC_BITS is constant.
    if (valid_n) begin
      dac_n  = plane_bits(ifm_n, ib_n);
      ones_n = new_plane_s ? popcount(dac_n) : ONES_COUNTER;
      wbp_n  = {{(BIT_W-1){1'b0}}, 1'b1} << wb_n;
      last_n = (ib_n == IB_MAX) && (wb_n == WB_MAX);
    end else begin
      dac_n  = {OUY{1'b0}};
      ones_n = {OW{1'b0}};
      wbp_n  = {BIT_W{1'b0}};
      last_n = 1'b0;
    end
  end

  // State, vector latch and all aligned step outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r             <= IDLE;
      ifm_r               <= {(OUY*BIT_IFM){1'b0}};
      DAC_BITS            <= {OUY{1'b0}};
      COL_SEL             <= {CW{1'b0}};
      WEIGHT_BIT_POSITION <= {BIT_W{1'b0}};
      ONES_COUNTER        <= {OW{1'b0}};
      INPUT_BIT_POSITION  <= {IW{1'b0}};
      seq_valid           <= 1'b0;
      seq_last            <= 1'b0;
    end else begin
      case (state_n)
        IDLE:    state_r <= IDLE;
        RUN:     state_r <= RUN;
        default: state_r <= IDLE;
      endcase
      ifm_r               <= ifm_n;
      DAC_BITS            <= dac_n;
      COL_SEL             <= wb_n & {CW{valid_n}};
      WEIGHT_BIT_POSITION <= wbp_n;
      ONES_COUNTER        <= ones_n;
      INPUT_BIT_POSITION  <= ib_n & {IW{valid_n}};
      seq_valid           <= valid_n;
      seq_last            <= last_n;
    end
  end

endmodule
